// File: rtl/booth4_ctrl.sv
// Sequencing controller for the 10x10 radix-4 Booth multiplier datapath.
// Issues load/clear, then ITER alternating ALU-load and shift-by-2 strobes, then a done pulse.
module booth4_ctrl #(
   parameter int ITER  = 5,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             ld_mcand,
   output logic             ld_mplier,
   output logic             clr_p,
   output logic             clr_qm1,
   output logic             ld_p,
   output logic             shift,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] cnt_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Saturating increment: the count never passes ITER.
   assign cnt_inc = (cnt == ITER_C) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_LOAD;
         end
         S_LOAD: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx   = '0;
               state_nx = S_ADD;
            end
         end
         S_ADD: begin
            state_nx = abort ? S_IDLE : S_SHIFT;
         end
         S_SHIFT: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx   = cnt_inc;
               state_nx = (cnt_inc == ITER_C) ? S_DONE : S_ADD;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Moore decode: every output depends on the registered state alone.
   always_comb begin
      ld_mcand  = 1'b0;
      ld_mplier = 1'b0;
      clr_p     = 1'b0;
      clr_qm1   = 1'b0;
      ld_p      = 1'b0;
      shift     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_LOAD: begin
            ld_mcand  = 1'b1;
            ld_mplier = 1'b1;
            clr_p     = 1'b1;
            clr_qm1   = 1'b1;
            busy      = 1'b1;
         end
         S_ADD: begin
            ld_p = 1'b1;
            busy = 1'b1;
         end
         S_SHIFT: begin
            shift = 1'b1;
            busy  = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign iter = cnt;

endmodule

// File: tb/tb_booth4_ctrl.sv
// Self-checking bench for booth4_ctrl: cycle-exact strobe checks, a behavioural
// Booth datapath driven by the strobes, and a product scoreboard.
module tb_booth4_ctrl;

   logic clk = 1'b0;
   logic rst, start, abort, start3;
   logic ld_mcand, ld_mplier, clr_p, clr_qm1, ld_p, shift, busy, done;
   logic [2:0] iter;
   logic ld_mcand3, ld_mplier3, clr_p3, clr_qm13, ld_p3, shift3, busy3, done3;
   logic [1:0] iter3;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   booth4_ctrl #(.ITER(5), .CNT_W(3)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ld_mcand(ld_mcand), .ld_mplier(ld_mplier), .clr_p(clr_p), .clr_qm1(clr_qm1),
      .ld_p(ld_p), .shift(shift), .busy(busy), .done(done), .iter(iter)
   );

   booth4_ctrl #(.ITER(3), .CNT_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(1'b0),
      .ld_mcand(ld_mcand3), .ld_mplier(ld_mplier3), .clr_p(clr_p3), .clr_qm1(clr_qm13),
      .ld_p(ld_p3), .shift(shift3), .busy(busy3), .done(done3), .iter(iter3)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected {ld_mcand,ld_mplier,clr_p,clr_qm1,ld_p,shift,busy,done} in cycle k
   // (cycle 1 = the cycle after start is sampled) for an ITER=n operation.
   function automatic logic [7:0] exp_vec(int k, int n);
      if (k == 1)                                 return 8'b1111_0010;
      if (k >= 2 && k <= 2*n+1 && (k % 2) == 0)   return 8'b0000_1010;
      if (k >= 3 && k <= 2*n+1)                   return 8'b0000_0110;
      if (k == 2*n+2)                             return 8'b0000_0001;
      return 8'b0;
   endfunction

   function automatic int exp_iter(int k, int n);
      return (k >= 2*n+2) ? n : (k - 2) / 2;
   endfunction

   task automatic chk_cycle(string tag, int k);
      check($sformatf("%s c%0d strobes", tag, k),
            {24'd0, ld_mcand, ld_mplier, clr_p, clr_qm1, ld_p, shift, busy, done},
            {24'd0, exp_vec(k, 5)});
      if (k >= 2) check($sformatf("%s c%0d iter", tag, k), {29'd0, iter}, exp_iter(k, 5));
   endtask

   task automatic chk_idle(string tag, int exp_it);
      check({tag, " strobes"},
            {24'd0, ld_mcand, ld_mplier, clr_p, clr_qm1, ld_p, shift, busy, done}, 32'd0);
      check({tag, " iter"}, {29'd0, iter}, exp_it);
   endtask

   // Behavioural Booth datapath with guard bits in the product half.
   logic signed [13:0] dp_p;
   logic        [9:0]  dp_q, dp_m;
   logic               dp_qm1;
   logic        [9:0]  dp_a, dp_b;
   logic signed [13:0] m14;
   logic        [19:0] product;

   assign m14     = {{4{dp_m[9]}}, dp_m};
   assign product = {dp_p[9:0], dp_q};

   function automatic logic signed [13:0] bsel(logic [2:0] s, logic signed [13:0] m);
      case (s)
         3'b001, 3'b010: return m;
         3'b011:         return m <<< 1;
         3'b100:         return -(m <<< 1);
         3'b101, 3'b110: return -m;
         default:        return 14'sd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (ld_mcand)  dp_m   <= dp_a;
      if (ld_mplier) dp_q   <= dp_b;
      if (clr_p)     dp_p   <= '0;
      if (clr_qm1)   dp_qm1 <= 1'b0;
      if (ld_p)      dp_p   <= dp_p + bsel({dp_q[1:0], dp_qm1}, m14);
      if (shift) begin
         dp_p   <= dp_p >>> 2;
         dp_q   <= {dp_p[1:0], dp_q[9:2]};
         dp_qm1 <= dp_q[1];
      end
   end

   logic [19:0] sb_q[$];
   int blen = 0, blen3 = 0;

   always @(negedge clk) begin
      if (!rst) begin
         check("excl", {29'd0, 3'(ld_mcand) + 3'(ld_p) + 3'(shift)} > 1 ||
               !({ld_mcand, ld_mplier, clr_p, clr_qm1} inside {4'h0, 4'hF}), 0);
         check("excl3", {29'd0, 3'(ld_mcand3) + 3'(ld_p3) + 3'(shift3)} > 1, 0);
      end
      blen  <= busy  ? blen + 1  : 0;
      blen3 <= busy3 ? blen3 + 1 : 0;
      if (!busy && done)   check("busy_len", blen, 11);
      if (!busy3 && done3) check("busy_len3", blen3, 7);
      if (done) begin
         if (sb_q.size() == 0) check("unexpected done", 1, 0);
         else check("product", {12'd0, product}, {12'd0, sb_q.pop_front()});
      end
   end

   typedef struct {
      logic [9:0]  a;
      logic [9:0]  b;
      logic [19:0] p;
   } vec_t;

   vec_t vecs[6];

   task automatic run_op(string tag, logic [9:0] a, logic [9:0] b, logic [19:0] p, logic ab);
      dp_a = a; dp_b = b; start = 1'b1; abort = ab;
      sb_q.push_back(p);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         chk_cycle(tag, k);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vecs[0] = '{10'd11,   10'd23,   20'd253};
      vecs[1] = '{10'h3F9,  10'd13,   20'hFFFA5};
      vecs[2] = '{10'h200,  10'h200,  20'h40000};
      vecs[3] = '{10'd511,  10'h200,  20'hC0200};
      vecs[4] = '{10'd0,    10'd77,   20'd0};
      vecs[5] = '{10'h3FF,  10'h3FF,  20'd1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
      dp_a = '0; dp_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset", 0);
      check("reset dut3", {22'd0, ld_mcand3, ld_p3, shift3, busy3, done3, iter3}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle("post-reset", 0);

      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);

      // start held high: three operations, period 13
      dp_a = 10'd11; dp_b = 10'd23; start = 1'b1;
      repeat (3) sb_q.push_back(20'd253);
      @(posedge clk); #1;
      for (int c = 1; c <= 39; c++) begin
         chk_cycle("b2b", ((c - 1) % 13) + 1);
         if (c == 38) start = 1'b0;
         @(posedge clk); #1;
      end
      chk_idle("b2b end", 5);

      // abort in the third ADD cycle
      dp_a = 10'd5; dp_b = 10'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         chk_cycle("abort", k);
         if (k == 6) abort = 1'b1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      chk_idle("abort c7", 2);
      @(posedge clk); #1;
      chk_idle("abort c8", 2);
      run_op("after abort", 10'd100, 10'h3FE, 20'hFFF38, 1'b0);

      // rst during the fourth SHIFT cycle
      dp_a = 10'd7; dp_b = 10'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         chk_cycle("rst", k);
         if (k == 9) rst = 1'b1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      chk_idle("rst c10", 0);
      run_op("after rst", 10'd200, 10'd3, 20'd600, 1'b0);

      // start and abort together in IDLE: start wins
      run_op("start+abort", 10'd12, 10'd12, 20'd144, 1'b1);

      // ITER=3 instance
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         check($sformatf("iter3 c%0d strobes", k),
               {24'd0, ld_mcand3, ld_mplier3, clr_p3, clr_qm13, ld_p3, shift3, busy3, done3},
               {24'd0, exp_vec(k, 3)});
         if (k >= 2) check($sformatf("iter3 c%0d iter", k), {30'd0, iter3}, exp_iter(k, 3));
         @(posedge clk); #1;
      end

      check("scoreboard empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/booth4_ctrl.md
# booth4_ctrl

Sequencing controller for the 10x10 radix-4 (bit-pair Booth) multiplier datapath. It accepts a start request, then drives the datapath strobes in order:

- load multiplicand and multiplier, clear the product half;
- alternate ALU-load and 2-bit-shift cycles for ITER iterations;
- signal completion.

It replaces the hand-toggled ldP/shift/count stimulus, and owns the iteration count the datapath previously kept.

## Interface
Parameters:
- ITER, 5, number of add/shift iterations (10-bit multiplier / 2 bits per step)
- CNT_W, 3, width of iteration counter; must satisfy 2^CNT_W > ITER

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset rst, synchronous, active-high
- start  input  1  request a multiply; sampled only in IDLE
- abort  input  1  cancel an operation in progress; no done generated
- ld_mcand  output  1  load multiplicand register
- ld_mplier  output  1  load multiplier (low) half of product/multiplier shift register
- clr_p  output  1  synchronous clear of product (high) half
- clr_qm1  output  1  synchronous clear of Booth q[-1] flop
- ld_p  output  1  load ALU result into product half
- shift  output  1  arithmetic shift right by 2 of the 20-bit register; also captures q[-1]
- busy  output  1  high from LOAD through last SHIFT
- done  output  1  one-cycle pulse; product valid in datapath
- iter  output  CNT_W  completed-iteration count (0..ITER)

## Operation
States: IDLE, LOAD, ADD, SHIFT, DONE. All outputs are Moore, decoded from the state only.

Per-state behaviour:
- IDLE: all strobes 0, busy 0. Transition is start=1 -> LOAD; otherwise stay.
- LOAD: ld_mcand=ld_mplier=clr_p=clr_qm1=1, busy=1. The iteration counter clears to 0. Always -> ADD.
- ADD: ld_p=1, busy=1. The ALU select is formed by the datapath from {q1,q0,q[-1]}; the controller does not decode it. Always -> SHIFT.
- SHIFT: shift=1, busy=1. The counter increments.
  - If the incremented value equals ITER -> DONE.
  - Otherwise -> ADD.
- DONE: done=1, busy=0, iter holds ITER. Always -> IDLE.

Strobe constraints:
- ld_p and shift are mutually exclusive in every state.
- At most one of {LOAD strobes, ld_p, shift} is active in any cycle.

Abort, start and reset rules:
- abort=1 in LOAD, ADD or SHIFT -> IDLE next cycle; no done, and iter keeps its value. abort is ignored in IDLE and DONE.
- start while busy or in DONE is ignored, not queued.
- Simultaneous abort and start in IDLE: start wins (abort is ignored in IDLE).
- Iteration counter width is CNT_W. It never wraps: it saturates at ITER and is only cleared in LOAD or by rst.

## Timing
- Reset values: state IDLE, iter 0, all strobes 0, busy 0, done 0.
- rst is synchronous, has priority over start and abort, and is legal mid-operation. The cycle after rst is sampled high, the block is in IDLE with all outputs 0.
- Latency for ITER=5, counted from the start-sampled edge:
  - cycle 1: LOAD;
  - cycles 2..11: ADD/SHIFT pairs;
  - cycle 12: done=1.
  - In general: done asserts 2*ITER+2 cycles after start is sampled.
- Back-to-back operation: start may be high in the first IDLE cycle after DONE, giving a period of 2*ITER+3 cycles.
- busy is high for exactly 2*ITER+1 consecutive cycles per completed operation.
- No combinational path from any input to any output.

## Test plan
- Reset, then start pulse with Mpand=11, Mplier=23:
  - LOAD at cycle 1;
  - ld_p at cycles 2,4,6,8,10 and shift at cycles 3,5,7,9,11;
  - done at cycle 12, datapath result 253.
- Signed operands Mpand=-7 (0x3F9), Mplier=13 -> done after 12 cycles, result 20'hFFFA5 (-91). Checks that the ADD/SHIFT cadence holds across subtract selects.
- start held continuously high:
  - operations repeat every 13 cycles;
  - exactly one done per operation;
  - start during busy causes no extra LOAD.
- abort asserted in the third ADD cycle (cycle 6) -> IDLE at cycle 7, no done, iter=2. A following start runs a full clean operation with iter restarting from 0.
- rst asserted during SHIFT cycle 9 -> next cycle IDLE, iter=0, all strobes 0. Then start -> normal 12-cycle completion.
- Strobe-exclusivity and busy-length assertions checked across all of the above. Also rerun with ITER=3 -> done at cycle 8.
